fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_DEPTH, default 256, instruction memory depth in bytes; used only for range check.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  fetch enable.
REQ-006 SHALL have port redirect  input  1  branch/jump taken; flush and reload PC.
REQ-007 SHALL have port redirect_pc  input  32  redirect target address.
REQ-008 SHALL have port imem_addr  output  32  byte address to instruction memory (combinational read).
REQ-009 SHALL have port imem_data  input  32  instruction word returned in the same cycle.
REQ-010 SHALL have port id_ready  input  1  decode stage accepts the IF/ID register this cycle.
REQ-011 SHALL have port id_valid  output  1  IF/ID register holds a valid instruction.
REQ-012 SHALL have ports id_instr, id_pc, id_pc_plus4  output  32 each  captured instruction, its PC, and PC+4.
REQ-013 SHALL have port fetch_err  output  1  sticky error: misaligned or out-of-range fetch.

Function
REQ-014 SHALL drive imem_addr = pc combinationally.
REQ-015 SHALL implement FSM IDLE, RUN, HALT; reset state IDLE.
REQ-016 IDLE: no capture, pc held; en=1 -> RUN next edge.
REQ-017 RUN: "advance" = !id_valid || id_ready. On advance, capture imem_data/pc/pc+4 into IF/ID, set id_valid=1, pc <= pc+4.
REQ-018 RUN with id_valid=1 and id_ready=0 SHALL hold pc and IF/ID unchanged (stall).
REQ-019 Latency: the word at address A SHALL appear on id_instr the cycle after imem_addr=A.
REQ-020 redirect=1 SHALL win over stall and advance: pc <= redirect_pc, id_valid <= 0; first target instruction valid two edges later.
REQ-021 RUN with en=0 SHALL stop capturing, clear id_valid when the held entry is consumed, then go to IDLE; en=0 with redirect applies the redirect first.
REQ-022 If redirect_pc[1:0]!=0 or pc > IMEM_DEPTH-4, SHALL set fetch_err, clear id_valid, and go to HALT.
REQ-023 HALT SHALL be left only by rst; outputs hold, id_valid=0.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0); the range check then governs.

Reset
REQ-025 rst=1 at an edge SHALL set pc=RESET_PC, state=IDLE, id_valid=0, id_instr=id_pc=id_pc_plus4=0, fetch_err=0, counters=0.
REQ-026 Reset SHALL take priority over redirect, en and stall, including mid-stall.

Configuration
REQ-027 With macro FETCH_PERF_CNT_EN defined, SHALL add outputs fetch_cnt[31:0] (advances with capture) and stall_cnt[31:0] (cycles in RUN with id_valid&&!id_ready), both saturating at 32'hFFFF_FFFF.
REQ-028 Without FETCH_PERF_CNT_EN, these ports and counters SHALL NOT exist.

Structure
REQ-029 Package mips_pkg SHALL hold the fetch FSM state enum, the IF/ID struct (instr, pc, pc_plus4), and constants INSTR_BYTES=4 and NOP=32'h0000_0000.
REQ-030 The IF/ID register SHALL be a sub-module if_id_reg (valid/ready hold register with flush).

Verification
REQ-031 Reset, en=1, id_ready=1, mem words 0x20080005, 0x20090003 at 0/4 -> id_instr=0x20080005 with id_pc=0, then 0x20090003 with id_pc=4.
REQ-032 id_ready=0 for 3 cycles while id_pc=8 -> id_pc, id_instr and imem_addr=12 stable; release -> id_pc=12 next edge.
REQ-033 redirect=1, redirect_pc=0x40, concurrent with stall -> id_valid=0 next edge, then id_pc=0x40.
REQ-034 redirect_pc=0x42 -> fetch_err=1, state HALT, id_valid=0 until rst.
REQ-035 rst asserted mid-stall with pc=0x10 -> pc=RESET_PC, id_valid=0, IDLE; en required to restart.
REQ-036 With FETCH_PERF_CNT_EN, 5 fetches and 2 stall cycles -> fetch_cnt=5, stall_cnt=2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch pipeline: fetch FSM state
// encoding, the IF/ID payload struct, instruction size and NOP encoding.
package mips_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP         = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: a valid/ready hold register. Flush clears only the
// valid bit so the last captured payload stays visible on the outputs.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);

  logic   valid_q, valid_d;
  if_id_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= 1'b0;
      data_q.instr    <= NOP;
      data_q.pc       <= '0;
      data_q.pc_plus4 <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IDLE/RUN/HALT control and the IF/ID register.
// Optional perf counters (fetch_cnt, stall_cnt) under `FETCH_PERF_CNT_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [31:0] PC_MAX = 32'(IMEM_DEPTH - int'(INSTR_BYTES));

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         err_q, err_d;
  logic [31:0]  pc_plus4;
  logic         stall, advance, load, flush;
  if_id_t       if_id_d, if_id_q;

  assign pc_plus4  = pc_q + 32'(INSTR_BYTES);
  assign stall     = id_valid && !id_ready;
  assign advance   = !stall;
  assign imem_addr = pc_q;

  assign if_id_d.instr    = imem_data;
  assign if_id_d.pc       = pc_q;
  assign if_id_d.pc_plus4 = pc_plus4;

  // Priority inside RUN: redirect, then disable/drain, then range check and capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        if (en) state_d = FS_RUN;
      end
      FS_RUN: begin
        if (redirect) begin
          flush = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = FS_HALT;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (!en) begin
          if (!stall) begin
            flush   = 1'b1;
            state_d = FS_IDLE;
          end
        end else if (advance) begin
          if (pc_q > PC_MAX || pc_q[1:0] != 2'b00) begin
            err_d   = 1'b1;
            flush   = 1'b1;
            state_d = FS_HALT;
          end else begin
            load = 1'b1;
            pc_d = pc_plus4;
          end
        end
      end
      FS_HALT: state_d = FS_HALT;
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign fetch_err = err_q;

  if_id_reg u_if_id_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .flush(flush),
    .d    (if_id_d),
    .valid(id_valid),
    .q    (if_id_q)
  );

  assign id_instr    = if_id_q.instr;
  assign id_pc       = if_id_q.pc;
  assign id_pc_plus4 = if_id_q.pc_plus4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (load && fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (state_q == FS_RUN && stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; perf counter checks compile
// only when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_ready = 1'b1;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:63];
  assign imem_data = mem[imem_addr[7:2]];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4),
    .fetch_err  (fetch_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; redirect = 1'b0; id_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr); end
    vectors++; if (id_instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr got=%h exp=00000000", id_instr); end
    vectors++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL rst_pc got=%h/%h exp=0/0", id_pc, id_pc_plus4); end
    vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
    step();
    vectors++; if (id_valid !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL idle_hold got=%b/%h exp=0/00000000", id_valid, imem_addr); end
  endtask

  task automatic test_fetch();
    en = 1'b1; id_ready = 1'b1;
    step();
    vectors++; if (id_valid !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL start_run got=%b/%h exp=0/00000000", id_valid, imem_addr); end
    step();
    vectors++; if (id_valid !== 1'b1 || id_instr !== 32'h2008_0005) begin miscompares++; $display("FAIL fetch0_instr got=%b/%h exp=1/20080005", id_valid, id_instr); end
    vectors++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL fetch0_pc got=%h/%h exp=0/4", id_pc, id_pc_plus4); end
    vectors++; if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL fetch0_addr got=%h exp=00000004", imem_addr); end
    step();
    vectors++; if (id_instr !== 32'h2009_0003 || id_pc !== 32'h4) begin miscompares++; $display("FAIL fetch1 got=%h/%h exp=20090003/4", id_instr, id_pc); end
    step();
    vectors++; if (id_instr !== 32'hA000_0008 || id_pc !== 32'h8 || imem_addr !== 32'hC) begin miscompares++; $display("FAIL fetch2 got=%h/%h/%h exp=a0000008/8/c", id_instr, id_pc, imem_addr); end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'hA000_0008 || imem_addr !== 32'hC) begin
        miscompares++; $display("FAIL stall_hold%0d got=%b/%h/%h/%h exp=1/8/a0000008/c", i, id_valid, id_pc, id_instr, imem_addr);
      end
    end
    id_ready = 1'b1;
    step();
    vectors++; if (id_pc !== 32'hC || id_instr !== 32'hA000_000C || imem_addr !== 32'h10) begin miscompares++; $display("FAIL stall_release got=%h/%h/%h exp=c/a000000c/10", id_pc, id_instr, imem_addr); end
  endtask

  task automatic test_redirect();
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    vectors++; if (id_valid !== 1'b0 || imem_addr !== 32'h40) begin miscompares++; $display("FAIL redir_flush got=%b/%h exp=0/40", id_valid, imem_addr); end
    redirect = 1'b0; id_ready = 1'b1;
    step();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'hA000_0040) begin miscompares++; $display("FAIL redir_target got=%b/%h/%h exp=1/40/a0000040", id_valid, id_pc, id_instr); end
    vectors++; if (id_pc_plus4 !== 32'h44 || imem_addr !== 32'h44) begin miscompares++; $display("FAIL redir_next got=%h/%h exp=44/44", id_pc_plus4, imem_addr); end
  endtask

  task automatic test_en_off();
    en = 1'b0; id_ready = 1'b0;
    step();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin miscompares++; $display("FAIL enoff_hold got=%b/%h exp=1/40", id_valid, id_pc); end
    id_ready = 1'b1;
    step();
    vectors++; if (id_valid !== 1'b0 || imem_addr !== 32'h44) begin miscompares++; $display("FAIL enoff_drain got=%b/%h exp=0/44", id_valid, imem_addr); end
    step();
    vectors++; if (id_valid !== 1'b0 || imem_addr !== 32'h44) begin miscompares++; $display("FAIL enoff_idle got=%b/%h exp=0/44", id_valid, imem_addr); end
    en = 1'b1;
    step();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL enon_wait got=%b exp=0", id_valid); end
    step();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h44) begin miscompares++; $display("FAIL enon_fetch got=%b/%h exp=1/44", id_valid, id_pc); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    en = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vectors++; if (imem_addr !== 32'h10 || id_pc !== 32'hC) begin miscompares++; $display("FAIL pre_stall got=%h/%h exp=10/c", imem_addr, id_pc); end
    id_ready = 1'b0;
    step();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    step();
    rst = 1'b0; redirect = 1'b0; en = 1'b0; id_ready = 1'b1;
    vectors++; if (imem_addr !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h0 || fetch_err !== 1'b0) begin
      miscompares++; $display("FAIL rst_stall got=%h/%b/%h/%b exp=0/0/0/0", imem_addr, id_valid, id_pc, fetch_err);
    end
    step(); step();
    vectors++; if (id_valid !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_idle got=%b/%h exp=0/0", id_valid, imem_addr); end
    en = 1'b1;
    step(); step();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h2008_0005) begin miscompares++; $display("FAIL rst_restart got=%b/%h/%h exp=1/0/20080005", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    vectors++; if (fetch_err !== 1'b1 || id_valid !== 1'b0) begin miscompares++; $display("FAIL misalign got=%b/%b exp=1/0", fetch_err, id_valid); end
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    step(); step();
    vectors++; if (fetch_err !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL halt_hold got=%b/%b/%h exp=1/0/4", fetch_err, id_valid, imem_addr); end
    do_reset();
    vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL halt_rst got=%b exp=0", fetch_err); end
  endtask

  task automatic test_range();
    en = 1'b1; id_ready = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'hFC;
    step();
    redirect = 1'b0;
    step();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'hFC || id_instr !== 32'hA000_00FC) begin miscompares++; $display("FAIL last_word got=%b/%h/%h exp=1/fc/a00000fc", id_valid, id_pc, id_instr); end
    vectors++; if (fetch_err !== 1'b0 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL last_next got=%b/%h exp=0/100", fetch_err, imem_addr); end
    step();
    vectors++; if (fetch_err !== 1'b1 || id_valid !== 1'b0) begin miscompares++; $display("FAIL out_of_range got=%b/%b exp=1/0", fetch_err, id_valid); end
    do_reset();
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    vectors++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin miscompares++; $display("FAIL cnt_rst got=%h/%h exp=0/0", fetch_cnt, stall_cnt); end
    en = 1'b1; id_ready = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    id_ready = 1'b0;
    step(); step();
    vectors++; if (fetch_cnt !== 32'd5) begin miscompares++; $display("FAIL fetch_cnt got=%0d exp=5", fetch_cnt); end
    vectors++; if (stall_cnt !== 32'd2) begin miscompares++; $display("FAIL stall_cnt got=%0d exp=2", stall_cnt); end
    do_reset();
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i * 4);
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_en_off();
    test_reset_mid_stall();
    test_misaligned();
    test_range();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
